// File: rtl/vliw_regfile_if.sv
// Register-file port bundle shared by all IEU lanes.
//   master: drives per-lane write enables, read/write addresses and write data
//           (the core's lanes, or a testbench).
//   slave : the register file. It returns per-lane read data plus the
//           registered collision and illegal-address status.
// Lane i occupies we3[i], a1/a2/a3[5i+4:5i] and wd3/rd1/rd2[XLEN*i+XLEN-1:XLEN*i].
interface vliw_regfile_if #(
  parameter int XLEN   = 64,
  parameter int NLANES = 4
);
  logic [NLANES-1:0]      we3;
  logic [5*NLANES-1:0]    a1;
  logic [5*NLANES-1:0]    a2;
  logic [5*NLANES-1:0]    a3;
  logic [XLEN*NLANES-1:0] wd3;
  logic [XLEN*NLANES-1:0] rd1;
  logic [XLEN*NLANES-1:0] rd2;
  logic                   WriteConflict;
  logic [NLANES-1:0]      ConflictMask;
  logic [15:0]            ConflictCount;
  logic                   IllegalAdr;

  modport master (
    output we3, a1, a2, a3, wd3,
    input  rd1, rd2, WriteConflict, ConflictMask, ConflictCount, IllegalAdr
  );

  modport slave (
    input  we3, a1, a2, a3, wd3,
    output rd1, rd2, WriteConflict, ConflictMask, ConflictCount, IllegalAdr
  );
endinterface

// File: rtl/vliw_regfile.sv
// Shared multi-ported integer register file for the STARBUG VLIW IEU lanes.
// Every lane gets two combinational read ports and one write port per cycle.
// Same-cycle writes to one register resolve in favour of the highest lane
// (latest in program order), and reads see same-cycle writes (write-through).
// Ports:
//   clk   : core clock
//   reset : synchronous, active-high; clears storage, flags and counter
//   rf    : slave side of vliw_regfile_if
//           rd1/rd2        combinational read data per lane
//           WriteConflict  a collision happened last cycle
//           ConflictMask   lanes whose write was dropped last cycle
//           ConflictCount  saturating count of collision cycles
//           IllegalAdr     an out-of-range address was in use last cycle
module vliw_regfile #(
  parameter int XLEN   = 64,
  parameter int NLANES = 4,
  parameter int NREGS  = 32
) (
  input  logic          clk,
  input  logic          reset,
  vliw_regfile_if.slave rf
);

  localparam int AW = $clog2(NREGS);

  // Slot 0 exists only to keep indexing simple; it is never written or read.
  logic [XLEN-1:0]        regs [NREGS];

  logic [4:0]             a1L  [NLANES];
  logic [4:0]             a2L  [NLANES];
  logic [4:0]             a3L  [NLANES];
  logic [XLEN-1:0]        wdL  [NLANES];
  logic [NLANES-1:0]      effWe;
  logic [NLANES-1:0]      lostMask;
  logic                   illegalNow;
  logic [XLEN*NLANES-1:0] rd1Comb;
  logic [XLEN*NLANES-1:0] rd2Comb;

  logic                   writeConflictQ;
  logic [NLANES-1:0]      conflictMaskQ;
  logic [15:0]            conflictCountQ;
  logic                   illegalAdrQ;

  // With 16 registers the fifth address bit marks an out-of-range access.
  function automatic logic isOob(input logic [4:0] a);
    return (NREGS == 16) && a[4];
  endfunction

  function automatic logic [15:0] satInc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  for (genvar i = 0; i < NLANES; i++) begin : gLane
    assign a1L[i]   = rf.a1[5*i +: 5];
    assign a2L[i]   = rf.a2[5*i +: 5];
    assign a3L[i]   = rf.a3[5*i +: 5];
    assign wdL[i]   = rf.wd3[XLEN*i +: XLEN];
    // x0 writes are discarded silently; out-of-range writes are dropped.
    assign effWe[i] = rf.we3[i] && (a3L[i] != 5'd0) && !isOob(a3L[i]);
  end

  // A lane loses when any later lane writes the same register this cycle.
  always_comb begin
    lostMask = '0;
    for (int i = 0; i < NLANES; i++) begin
      for (int j = i + 1; j < NLANES; j++) begin
        if (effWe[i] && effWe[j] && (a3L[i] == a3L[j])) begin
          lostMask[i] = 1'b1;
        end
      end
    end
  end

  // Read ports are always in use; the write port only when enabled.
  always_comb begin
    illegalNow = 1'b0;
    for (int i = 0; i < NLANES; i++) begin
      if (isOob(a1L[i]) || isOob(a2L[i]) || (rf.we3[i] && isOob(a3L[i]))) begin
        illegalNow = 1'b1;
      end
    end
  end

  // Ascending lane scan so the highest matching writer overrides the stored
  // value, matching the commit priority.
  always_comb begin
    rd1Comb = '0;
    rd2Comb = '0;
    for (int i = 0; i < NLANES; i++) begin
      if ((a1L[i] != 5'd0) && !isOob(a1L[i])) begin
        rd1Comb[XLEN*i +: XLEN] = regs[a1L[i][AW-1:0]];
        for (int j = 0; j < NLANES; j++) begin
          if (effWe[j] && (a3L[j] == a1L[i])) begin
            rd1Comb[XLEN*i +: XLEN] = wdL[j];
          end
        end
      end
      if ((a2L[i] != 5'd0) && !isOob(a2L[i])) begin
        rd2Comb[XLEN*i +: XLEN] = regs[a2L[i][AW-1:0]];
        for (int j = 0; j < NLANES; j++) begin
          if (effWe[j] && (a3L[j] == a2L[i])) begin
            rd2Comb[XLEN*i +: XLEN] = wdL[j];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NREGS; k++) begin
        regs[k] <= '0;
      end
      writeConflictQ <= 1'b0;
      conflictMaskQ  <= '0;
      conflictCountQ <= '0;
      illegalAdrQ    <= 1'b0;
    end else begin
      for (int i = 0; i < NLANES; i++) begin
        if (effWe[i] && !lostMask[i]) begin
          regs[a3L[i][AW-1:0]] <= wdL[i];
        end
      end
      writeConflictQ <= |lostMask;
      conflictMaskQ  <= lostMask;
      illegalAdrQ    <= illegalNow;
      if (|lostMask) begin
        conflictCountQ <= satInc(conflictCountQ);
      end
    end
  end

  assign rf.rd1           = rd1Comb;
  assign rf.rd2           = rd2Comb;
  assign rf.WriteConflict = writeConflictQ;
  assign rf.ConflictMask  = conflictMaskQ;
  assign rf.ConflictCount = conflictCountQ;
  assign rf.IllegalAdr    = illegalAdrQ;

endmodule

// File: tb/tb_vliw_regfile.sv
// Testbench for vliw_regfile: a driver issues one bundle per cycle and pushes
// the expected response from a behavioural model into a queue; a monitor pops
// and compares mid-cycle. A second 16-register instance covers the
// out-of-range path.
module tb_vliw_regfile;

  typedef struct {
    logic [255:0] rd1;
    logic [255:0] rd2;
    logic [3:0]   mask;
    logic         wc;
    logic         ill;
    logic [15:0]  cnt;
    bit           chkRd;
    bit           chkFl;
  } expRec_t;

  logic clk;
  logic reset;

  vliw_regfile_if #(.XLEN(64), .NLANES(4)) ifM ();
  vliw_regfile_if #(.XLEN(64), .NLANES(4)) ifE ();

  vliw_regfile #(.XLEN(64), .NLANES(4), .NREGS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .rf    (ifM)
  );

  vliw_regfile #(.XLEN(64), .NLANES(4), .NREGS(16)) dutE (
    .clk   (clk),
    .reset (reset),
    .rf    (ifE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nErrors = 0;

  expRec_t q[$];

  // Behavioural model state: architectural registers and last-cycle status.
  logic [63:0] mem [32];
  logic [3:0]  expMask;
  logic        expWc;
  logic        expIll;
  logic [15:0] expCnt;
  bit          flagsKnown;

  // Per-cycle bundle being issued.
  logic [3:0]  drWe;
  logic [4:0]  drA1 [4];
  logic [4:0]  drA2 [4];
  logic [4:0]  drA3 [4];
  logic [63:0] drWd [4];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic clearDr();
    drWe = '0;
    for (int l = 0; l < 4; l++) begin
      drA1[l] = '0;
      drA2[l] = '0;
      drA3[l] = '0;
      drWd[l] = '0;
    end
  endtask

  // Issue one bundle, predict the response, optionally queue it for checking.
  // Reads observe the register state after this bundle's writes are applied
  // in program (lane) order.
  task automatic step(input bit rst, input bit doChk);
    expRec_t     e;
    logic [63:0] nxt [32];
    int          lastW [32];
    logic [3:0]  lost;
    reset = rst;
    ifM.we3 = drWe;
    for (int l = 0; l < 4; l++) begin
      ifM.a1[5*l +: 5]   = drA1[l];
      ifM.a2[5*l +: 5]   = drA2[l];
      ifM.a3[5*l +: 5]   = drA3[l];
      ifM.wd3[64*l +: 64] = drWd[l];
    end
    for (int r = 0; r < 32; r++) begin
      nxt[r]   = mem[r];
      lastW[r] = -1;
    end
    for (int l = 0; l < 4; l++) begin
      if (drWe[l] && drA3[l] != 5'd0) begin
        nxt[drA3[l]]   = drWd[l];
        lastW[drA3[l]] = l;
      end
    end
    lost = '0;
    for (int l = 0; l < 4; l++) begin
      if (drWe[l] && drA3[l] != 5'd0 && lastW[drA3[l]] != l) lost[l] = 1'b1;
    end
    e.rd1 = '0;
    e.rd2 = '0;
    for (int l = 0; l < 4; l++) begin
      e.rd1[64*l +: 64] = (drA1[l] == 5'd0) ? 64'd0 : nxt[drA1[l]];
      e.rd2[64*l +: 64] = (drA2[l] == 5'd0) ? 64'd0 : nxt[drA2[l]];
    end
    e.mask  = expMask;
    e.wc    = expWc;
    e.ill   = expIll;
    e.cnt   = expCnt;
    e.chkRd = !rst;
    e.chkFl = flagsKnown;
    if (doChk) q.push_back(e);
    if (rst) begin
      for (int r = 0; r < 32; r++) mem[r] = '0;
      expMask    = '0;
      expWc      = 1'b0;
      expIll     = 1'b0;
      expCnt     = '0;
      flagsKnown = 1'b1;
    end else begin
      for (int r = 0; r < 32; r++) mem[r] = nxt[r];
      expMask = lost;
      expWc   = |lost;
      expIll  = 1'b0;
      if ((|lost) && expCnt != 16'hFFFF) expCnt = expCnt + 16'd1;
    end
    @(negedge clk);
  endtask

  // Monitor: the DUT presents a response every cycle; compare it whenever
  // an expectation is waiting.
  initial begin
    expRec_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chkRd) begin
          for (int l = 0; l < 4; l++) begin
            chk($sformatf("rd1_lane%0d", l), ifM.rd1[64*l +: 64], e.rd1[64*l +: 64]);
            chk($sformatf("rd2_lane%0d", l), ifM.rd2[64*l +: 64], e.rd2[64*l +: 64]);
          end
        end
        if (e.chkFl) begin
          chk("ConflictMask", 64'(ifM.ConflictMask), 64'(e.mask));
          chk("WriteConflict", 64'(ifM.WriteConflict), 64'(e.wc));
          chk("IllegalAdr", 64'(ifM.IllegalAdr), 64'(e.ill));
          chk("ConflictCount", 64'(ifM.ConflictCount), 64'(e.cnt));
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    clearDr();
    for (int r = 0; r < 32; r++) mem[r] = '0;
    expMask = '0; expWc = 1'b0; expIll = 1'b0; expCnt = '0; flagsKnown = 1'b0;
    ifM.we3 = '0; ifM.a1 = '0; ifM.a2 = '0; ifM.a3 = '0; ifM.wd3 = '0;
    ifE.we3 = '0; ifE.a1 = '0; ifE.a2 = '0; ifE.a3 = '0; ifE.wd3 = '0;
    @(negedge clk);
    step(1'b1, 1'b0);

    // 16-register instance: write to a3=20 must be dropped (not aliased to x4).
    reset = 1'b0;
    ifE.we3 = 4'b0100;
    ifE.a3[10 +: 5] = 5'd20;
    ifE.wd3[128 +: 64] = 64'h5555_AAAA_0000_0055;
    ifE.a1[0 +: 5] = 5'd4;
    #2;
    chk("E_rd_x4_during", ifE.rd1[63:0], 64'd0);
    chk("E_illegal_before", 64'(ifE.IllegalAdr), 64'd0);
    @(negedge clk);
    ifE.we3 = '0;
    #2;
    chk("E_illegal_set", 64'(ifE.IllegalAdr), 64'd1);
    chk("E_rd_x4_after", ifE.rd1[63:0], 64'd0);
    chk("E_no_conflict", 64'(ifE.WriteConflict), 64'd0);
    @(negedge clk);
    #2;
    chk("E_illegal_clear", 64'(ifE.IllegalAdr), 64'd0);
    @(negedge clk);

    // Reset then read every register on every lane and port.
    for (int c = 0; c < 8; c++) begin
      clearDr();
      for (int l = 0; l < 4; l++) begin
        drA1[l] = 5'(4*c + l);
        drA2[l] = 5'(31 - (4*c + l));
      end
      step(1'b0, 1'b1);
    end

    // Single write then read.
    clearDr(); drWe = 4'b0100; drA3[2] = 5'd5; drWd[2] = 64'hDEAD_BEEF;
    step(1'b0, 1'b1);
    clearDr(); drA1[0] = 5'd5;
    step(1'b0, 1'b1);

    // Same-cycle bypass.
    clearDr(); drWe = 4'b0010; drA3[1] = 5'd7; drWd[1] = 64'h1234; drA2[3] = 5'd7;
    step(1'b0, 1'b1);
    clearDr(); drA1[2] = 5'd7;
    step(1'b0, 1'b1);

    // Three-way collision on x9.
    clearDr(); drWe = 4'b1011;
    drA3[0] = 5'd9; drA3[1] = 5'd9; drA3[3] = 5'd9;
    drWd[0] = 64'hA; drWd[1] = 64'hB; drWd[3] = 64'hC; drA1[2] = 5'd9;
    step(1'b0, 1'b1);
    clearDr(); drA1[0] = 5'd9;
    step(1'b0, 1'b1);
    clearDr(); drA2[1] = 5'd9;
    step(1'b0, 1'b1);

    // Writes to x0 are neither stored nor conflicts.
    clearDr(); drWe = 4'b0011; drWd[0] = 64'h77; drWd[1] = 64'h88;
    step(1'b0, 1'b1);
    clearDr();
    step(1'b0, 1'b1);

    // Random bundles, write addresses in a small window to force collisions.
    for (int n = 0; n < 3000; n++) begin
      drWe = 4'($urandom);
      for (int l = 0; l < 4; l++) begin
        drA3[l] = 5'($urandom_range(0, 7));
        drA1[l] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        drA2[l] = 5'($urandom_range(0, 31));
        drWd[l] = {$urandom, $urandom};
      end
      step(1'b0, 1'b1);
    end

    // Saturate the collision counter.
    clearDr(); drWe = 4'b0011; drA3[0] = 5'd2; drA3[1] = 5'd2;
    for (int n = 0; n < 65536; n++) begin
      drWd[0] = 64'(n);
      drWd[1] = 64'(n + 1);
      step(1'b0, 1'b0);
    end
    clearDr(); drA1[0] = 5'd2;
    step(1'b0, 1'b1);
    clearDr();
    step(1'b0, 1'b1);

    // Reset dominates a same-cycle write.
    clearDr(); drWe = 4'b0001; drA3[0] = 5'd3; drWd[0] = 64'd1;
    step(1'b1, 1'b1);
    clearDr(); drA1[0] = 5'd3; drA2[3] = 5'd3; drA1[1] = 5'd9;
    step(1'b0, 1'b1);
    clearDr();
    step(1'b0, 1'b1);

    #5;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule

// File: doc/vliw_regfile.md
Name: vliw_regfile

Overview:
- Shared multi-ported integer register file that answers the widened register-file port of every IEU lane in the VLIW STARBUG core.
- Each lane drives two read addresses, one write address, a write enable and write data. The block returns two read values per lane.
- Resolves same-cycle write collisions between lanes and bypasses same-cycle writes to readers.
- Counts and flags collisions for the hazard unit and the performance counters.

Parameters:
- XLEN, 64, data width of each register.
- NLANES, 4, number of IEU lanes served. Lane index 0 to NLANES-1; a higher lane index is later in program order within a bundle.
- NREGS, 32, architectural register count. Legal values are 32 (I) and 16 (E).

Ports:
- clk  input  1  core clock.
- reset  input  1  synchronous, active-high reset.
- we3  input  NLANES  per-lane write enable; bit i belongs to lane i.
- a1  input  5*NLANES  per-lane read address, port 1; bits [5i+4:5i] belong to lane i.
- a2  input  5*NLANES  per-lane read address, port 2; same packing as a1.
- a3  input  5*NLANES  per-lane write address; same packing as a1.
- wd3  input  XLEN*NLANES  per-lane write data; bits [XLEN*i+XLEN-1:XLEN*i] belong to lane i.
- rd1  output  XLEN*NLANES  per-lane read data, port 1; same packing as wd3.
- rd2  output  XLEN*NLANES  per-lane read data, port 2; same packing as wd3.
- WriteConflict  output  1  registered: a collision occurred in the previous cycle.
- ConflictMask  output  NLANES  registered: lanes whose write was dropped in the previous cycle.
- ConflictCount  output  16  saturating count of collision cycles.
- IllegalAdr  output  1  registered: some address at or above NREGS was presented with its port in use in the previous cycle.

Behaviour:
- Storage: registers x1 to x(NREGS-1), each XLEN bits. x0 is not stored.
- Reset:
  - Every stored register clears to 0 on the first rising clk edge with reset=1.
  - WriteConflict, ConflictMask, IllegalAdr and ConflictCount all clear to 0.
  - Reset dominates every write in the same cycle; no register updates while reset=1.
- Effective write:
  - Lane i writes when we3[i]=1, a3_i != 0 and a3_i < NREGS.
  - Writes to x0 are ignored silently. They are not conflicts and not illegal.
  - a3_i >= NREGS with we3[i]=1: the write is dropped and IllegalAdr is set next cycle.
- Write commit:
  - Writes commit on the rising clk edge.
  - Collision: two or more effective writes target the same register. The highest-indexed writing lane wins; the others are dropped.
- Read path: combinational, zero latency.
  - Address 0 returns 0.
  - Address >= NREGS returns 0 and sets IllegalAdr next cycle.
  - Any other address returns the stored value, subject to the bypass below.
- Write-through bypass:
  - If any effective write in the current cycle targets the read address, the read returns the winning write data (highest writing lane), not the stored value.
  - This allows a Writeback-stage result from any lane to be read in Decode in the same cycle.
- Collision flags:
  - ConflictMask[i] is 1 next cycle iff lane i's effective write lost to a higher lane.
  - WriteConflict is the OR-reduction of ConflictMask.
  - Both are held for one cycle only; they are 0 in any cycle following a cycle with no collision.
- ConflictCount:
  - Increments by 1 on each edge where a collision occurred, regardless of how many registers collided in that cycle.
  - Saturates at 16'hFFFF; no wrap.
  - Cleared only by reset.
- Reads never stall. The block has no handshake; every port is serviced every cycle.
- NREGS=16: address bit 4 set means out-of-range.

Test Plan:
- Reset then read: assert reset one cycle, then read x1 to x31 on every lane/port -> all return 0, and ConflictCount=0.
- Single write then read: lane 2 writes x5=64'hDEAD_BEEF; next cycle lane 0 a1=5 -> rd1 lane0=64'hDEAD_BEEF, WriteConflict=0.
- Bypass: lane 1 writes x7=64'h1234 while lane 3 a2=7 in the same cycle -> rd2 lane3=64'h1234 that cycle; stored value afterwards is 64'h1234.
- Collision: lanes 0, 1 and 3 all write x9 with 64'hA, 64'hB and 64'hC -> x9=64'hC. Next cycle ConflictMask=4'b0011, WriteConflict=1, ConflictCount increments 0->1; the flags drop to 0 the following cycle.
- x0 and illegal address:
  - Lanes 0 and 1 both write x0 -> no conflict, x0 reads 0.
  - With NREGS=16, lane 2 writes a3=20 -> no register changes, IllegalAdr=1 for one cycle.
- Saturation and reset mid-operation:
  - Force 65536 collision cycles -> ConflictCount holds 16'hFFFF.
  - Assert reset in the same cycle as lane 0 writing x3=1 -> x3 reads 0 afterwards, and the counter and flags read 0.
